otter_branch_predictor: RTL and testbench

Parametrised branch target buffer with per-entry saturating direction counters for the pipelined OTTER core. The fetch stage looks it up combinationally with the current PC to choose the next PC. The execute stage trains it with each resolved branch or jump. It replaces the fixed "predict not taken, flush on taken" policy, and also reports mispredicts and keeps statistics counters.

---
 rtl/otter_branch_predictor.sv | 139 +++++++++++++
 tb/tb_otter_branch_predictor.sv | 413 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/otter_branch_predictor.sv
// Branch target buffer with per-entry saturating direction counters for the OTTER fetch stage.
// Lookup is combinational from IF_PC; execute-stage updates and statistics are registered.
module otter_branch_predictor #(
    parameter int unsigned ENTRIES   = 16,
    parameter int unsigned CTR_BITS  = 2,
    parameter int unsigned XLEN      = 32,
    parameter int unsigned STAT_BITS = 16
) (
    input  logic                 CLK,
    input  logic                 RESET,
    input  logic [XLEN-1:0]      IF_PC,
    output logic                 PRED_TAKEN,
    output logic [XLEN-1:0]      PRED_TARGET,
    input  logic                 UPD_VALID,
    input  logic [XLEN-1:0]      UPD_PC,
    input  logic                 UPD_TAKEN,
    input  logic [XLEN-1:0]      UPD_TARGET,
    input  logic                 UPD_IS_JUMP,
    input  logic                 UPD_PRED_TAKEN,
    input  logic [XLEN-1:0]      UPD_PRED_TARGET,
    input  logic                 INVALIDATE,
    output logic                 MISPREDICT,
    output logic [STAT_BITS-1:0] UPD_COUNT,
    output logic [STAT_BITS-1:0] MISS_COUNT
);

    localparam int unsigned IDX_BITS = $clog2(ENTRIES);
    localparam int unsigned TAG_BITS = XLEN - 2 - IDX_BITS;

    localparam logic [CTR_BITS-1:0]  CTR_MAX  = '1;
    localparam logic [CTR_BITS-1:0]  CTR_WT   = CTR_BITS'(1) << (CTR_BITS - 1);
    localparam logic [CTR_BITS-1:0]  CTR_WN   = CTR_WT - CTR_BITS'(1);
    localparam logic [STAT_BITS-1:0] STAT_MAX = '1;

    logic [ENTRIES-1:0]  valid_q, valid_d;
    logic [CTR_BITS-1:0] ctr_q [ENTRIES];
    logic [CTR_BITS-1:0] ctr_d [ENTRIES];
    logic [TAG_BITS-1:0] tag_q [ENTRIES];
    logic [XLEN-1:0]     target_q [ENTRIES];

    logic [STAT_BITS-1:0] upd_cnt_q, upd_cnt_d;
    logic [STAT_BITS-1:0] miss_cnt_q, miss_cnt_d;

    logic [IDX_BITS-1:0] if_idx, upd_idx;
    logic [TAG_BITS-1:0] if_tag, upd_tag;
    logic                if_hit, upd_hit;
    logic                tag_we, target_we;

    logic unused_pc_lsb;
    assign unused_pc_lsb = ^{IF_PC[1:0], UPD_PC[1:0]};

    assign if_idx  = IF_PC[IDX_BITS+1:2];
    assign if_tag  = IF_PC[XLEN-1:IDX_BITS+2];
    assign upd_idx = UPD_PC[IDX_BITS+1:2];
    assign upd_tag = UPD_PC[XLEN-1:IDX_BITS+2];

    assign if_hit  = valid_q[if_idx] && (tag_q[if_idx] == if_tag);
    assign upd_hit = valid_q[upd_idx] && (tag_q[upd_idx] == upd_tag);

    always_comb begin
        PRED_TAKEN  = if_hit && ctr_q[if_idx][CTR_BITS-1];
        PRED_TARGET = PRED_TAKEN ? target_q[if_idx] : IF_PC + XLEN'(4);
    end

    assign MISPREDICT = UPD_VALID &&
                        ((UPD_PRED_TAKEN != UPD_TAKEN) ||
                         (UPD_TAKEN && (UPD_PRED_TARGET != UPD_TARGET)));

    always_comb begin
        valid_d   = valid_q;
        ctr_d     = ctr_q;
        tag_we    = 1'b0;
        target_we = 1'b0;
        if (INVALIDATE) begin
            // Coincident update is dropped; ctr/tag/target survive the flush.
            valid_d = '0;
        end else if (UPD_VALID) begin
            if (upd_hit) begin
                if (UPD_IS_JUMP) begin
                    ctr_d[upd_idx] = CTR_MAX;
                    target_we      = 1'b1;
                end else if (UPD_TAKEN) begin
                    if (ctr_q[upd_idx] != CTR_MAX) begin
                        ctr_d[upd_idx] = ctr_q[upd_idx] + CTR_BITS'(1);
                    end
                    target_we = 1'b1;
                end else if (ctr_q[upd_idx] != '0) begin
                    ctr_d[upd_idx] = ctr_q[upd_idx] - CTR_BITS'(1);
                end
            end else if (UPD_TAKEN) begin
                valid_d[upd_idx] = 1'b1;
                ctr_d[upd_idx]   = UPD_IS_JUMP ? CTR_MAX : CTR_WT;
                tag_we           = 1'b1;
                target_we        = 1'b1;
            end
        end
    end

    always_comb begin
        upd_cnt_d  = upd_cnt_q;
        miss_cnt_d = miss_cnt_q;
        if (UPD_VALID && (upd_cnt_q != STAT_MAX)) begin
            upd_cnt_d = upd_cnt_q + STAT_BITS'(1);
        end
        if (MISPREDICT && (miss_cnt_q != STAT_MAX)) begin
            miss_cnt_d = miss_cnt_q + STAT_BITS'(1);
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            valid_q    <= '0;
            ctr_q      <= '{default: CTR_WN};
            upd_cnt_q  <= '0;
            miss_cnt_q <= '0;
        end else begin
            valid_q    <= valid_d;
            ctr_q      <= ctr_d;
            upd_cnt_q  <= upd_cnt_d;
            miss_cnt_q <= miss_cnt_d;
        end
    end

    // Tag and target are qualified by valid, so they carry no reset.
    always_ff @(posedge CLK) begin
        if (!RESET) begin
            if (tag_we) begin
                tag_q[upd_idx] <= upd_tag;
            end
            if (target_we) begin
                target_q[upd_idx] <= UPD_TARGET;
            end
        end
    end

    assign UPD_COUNT  = upd_cnt_q;
    assign MISS_COUNT = miss_cnt_q;

endmodule

// File: tb/tb_otter_branch_predictor.sv
// Self-checking bench for otter_branch_predictor: directed scenarios plus randomized traffic
// checked against an array-based model of the BTB.
module tb_otter_branch_predictor;

    localparam int ENT  = 16;
    localparam int MAXC = 3;
    localparam int WT   = 2;
    localparam int WN   = 1;
    localparam int SB   = 8;
    localparam int SMAX = 255;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] if_pc;
    logic        pred_taken;
    logic [31:0] pred_target;
    logic        upd_valid;
    logic [31:0] upd_pc;
    logic        upd_taken;
    logic [31:0] upd_target;
    logic        upd_is_jump;
    logic        upd_pred_taken;
    logic [31:0] upd_pred_target;
    logic        invalidate;
    logic        mispredict;
    logic [SB-1:0] upd_count;
    logic [SB-1:0] miss_count;

    int n_cmp  = 0;
    int n_fail = 0;

    // Reference model state
    bit          m_valid [ENT];
    int          m_ctr   [ENT];
    logic [31:0] m_tag   [ENT];
    logic [31:0] m_tgt   [ENT];
    int          m_upd;
    int          m_miss;

    otter_branch_predictor #(
        .ENTRIES  (16),
        .CTR_BITS (2),
        .XLEN     (32),
        .STAT_BITS(SB)
    ) dut (
        .CLK            (clk),
        .RESET          (reset),
        .IF_PC          (if_pc),
        .PRED_TAKEN     (pred_taken),
        .PRED_TARGET    (pred_target),
        .UPD_VALID      (upd_valid),
        .UPD_PC         (upd_pc),
        .UPD_TAKEN      (upd_taken),
        .UPD_TARGET     (upd_target),
        .UPD_IS_JUMP    (upd_is_jump),
        .UPD_PRED_TAKEN (upd_pred_taken),
        .UPD_PRED_TARGET(upd_pred_target),
        .INVALIDATE     (invalidate),
        .MISPREDICT     (mispredict),
        .UPD_COUNT      (upd_count),
        .MISS_COUNT     (miss_count)
    );

    always #5 clk = ~clk;

    function automatic int pc_idx(input logic [31:0] pc);
        return int'((pc / 4) % ENT);
    endfunction

    function automatic logic [31:0] pc_tag(input logic [31:0] pc);
        return pc / (4 * ENT);
    endfunction

    function automatic void model_lookup(input logic [31:0] pc, output logic tk,
                                         output logic [31:0] tg);
        int  i;
        bit  hit;
        i   = pc_idx(pc);
        hit = m_valid[i] && (m_tag[i] == pc_tag(pc));
        tk  = hit && (m_ctr[i] >= WT);
        tg  = tk ? m_tgt[i] : pc + 32'd4;
    endfunction

    function automatic bit model_mispredict();
        if (!upd_valid) return 1'b0;
        if (upd_pred_taken != upd_taken) return 1'b1;
        return upd_taken && (upd_pred_target != upd_target);
    endfunction

    // Advance the model by one clock edge using the inputs currently driven.
    function automatic void model_step();
        int i;
        bit hit;
        if (reset) begin
            for (int k = 0; k < ENT; k++) begin
                m_valid[k] = 1'b0;
                m_ctr[k]   = WN;
            end
            m_upd  = 0;
            m_miss = 0;
            return;
        end
        if (upd_valid && m_upd < SMAX) m_upd++;
        if (model_mispredict() && m_miss < SMAX) m_miss++;
        if (invalidate) begin
            for (int k = 0; k < ENT; k++) m_valid[k] = 1'b0;
        end else if (upd_valid) begin
            i   = pc_idx(upd_pc);
            hit = m_valid[i] && (m_tag[i] == pc_tag(upd_pc));
            if (hit && upd_is_jump) begin
                m_ctr[i] = MAXC;
                m_tgt[i] = upd_target;
            end else if (hit && upd_taken) begin
                m_ctr[i] = (m_ctr[i] + 1 > MAXC) ? MAXC : m_ctr[i] + 1;
                m_tgt[i] = upd_target;
            end else if (hit) begin
                m_ctr[i] = (m_ctr[i] - 1 < 0) ? 0 : m_ctr[i] - 1;
            end else if (upd_taken) begin
                m_valid[i] = 1'b1;
                m_tag[i]   = pc_tag(upd_pc);
                m_tgt[i]   = upd_target;
                m_ctr[i]   = upd_is_jump ? MAXC : WT;
            end
        end
    endfunction

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic drive_idle();
        reset           = 1'b0;
        invalidate      = 1'b0;
        upd_valid       = 1'b0;
        upd_pc          = 32'h0;
        upd_taken       = 1'b0;
        upd_target      = 32'h0;
        upd_is_jump     = 1'b0;
        upd_pred_taken  = 1'b0;
        upd_pred_target = 32'h0;
    endtask

    task automatic drive_upd(input logic [31:0] pc, input logic tk, input logic [31:0] tg,
                             input logic jmp, input logic ptk, input logic [31:0] ptg);
        upd_valid       = 1'b1;
        upd_pc          = pc;
        upd_taken       = tk;
        upd_target      = tg;
        upd_is_jump     = jmp;
        upd_pred_taken  = ptk;
        upd_pred_target = ptg;
    endtask

    task automatic test_reset();
        drive_idle();
        reset = 1'b1;
        if_pc = 32'h100;
        drive_upd(32'h100, 1'b1, 32'h200, 1'b0, 1'b0, 32'h0);
        repeat (3) tick();
        drive_idle();
        #1;
        n_cmp++;
        if (pred_taken !== 1'b0) begin
            n_fail++; $display("FAIL reset_pred_taken: got %b want 0", pred_taken);
        end
        n_cmp++;
        if (pred_target !== 32'h104) begin
            n_fail++; $display("FAIL reset_pred_target: got %h want 00000104", pred_target);
        end
        n_cmp++;
        if (upd_count !== 0 || miss_count !== 0) begin
            n_fail++;
            $display("FAIL reset_counts: got upd=%0d miss=%0d want 0/0", upd_count, miss_count);
        end
        if_pc = 32'hFFFF_FFFC;
        #1;
        n_cmp++;
        if (pred_target !== 32'h0) begin
            n_fail++; $display("FAIL pc_wrap: got %h want 00000000", pred_target);
        end
        if_pc = 32'h100;
    endtask

    task automatic test_taken_alloc();
        drive_upd(32'h100, 1'b1, 32'h200, 1'b0, 1'b0, 32'h104);
        #1;
        n_cmp++;
        if (mispredict !== 1'b1) begin
            n_fail++; $display("FAIL alloc_mispredict: got %b want 1", mispredict);
        end
        n_cmp++;
        if (pred_taken !== 1'b0) begin
            n_fail++; $display("FAIL alloc_no_bypass: got %b want 0", pred_taken);
        end
        tick();
        drive_idle();
        #1;
        n_cmp++;
        if (miss_count !== 8'd1) begin
            n_fail++; $display("FAIL alloc_miss_count: got %0d want 1", miss_count);
        end
        n_cmp++;
        if (pred_taken !== 1'b1 || pred_target !== 32'h200) begin
            n_fail++;
            $display("FAIL alloc_lookup: got %b/%h want 1/00000200", pred_taken, pred_target);
        end
    endtask

    task automatic test_counter_training();
        for (int k = 0; k < 3; k++) begin
            drive_upd(32'h100, 1'b1, 32'h200, 1'b0, 1'b1, 32'h200);
            tick();
        end
        drive_idle();
        #1;
        n_cmp++;
        if (m_ctr[0] != MAXC || pred_taken !== 1'b1) begin
            n_fail++;
            $display("FAIL ctr_saturate: got taken=%b want 1 (model ctr %0d)", pred_taken,
                     m_ctr[0]);
        end
        for (int k = 0; k < 3; k++) begin
            drive_upd(32'h100, 1'b0, 32'h104, 1'b0, 1'b1, 32'h200);
            tick();
            drive_idle();
            #1;
            n_cmp++;
            if (pred_taken !== (k == 0)) begin
                n_fail++;
                $display("FAIL ctr_not_taken_%0d: got %b want %b", k, pred_taken, k == 0);
            end
        end
        n_cmp++;
        if (pred_target !== 32'h104) begin
            n_fail++; $display("FAIL ctr_nt_target: got %h want 00000104", pred_target);
        end
        // One taken from zero must land on 1 (still predicted not taken).
        drive_upd(32'h100, 1'b1, 32'h200, 1'b0, 1'b0, 32'h104);
        tick();
        drive_idle();
        #1;
        n_cmp++;
        if (pred_taken !== 1'b0) begin
            n_fail++; $display("FAIL ctr_floor: got %b want 0", pred_taken);
        end
    endtask

    task automatic test_alias();
        drive_upd(32'h140, 1'b1, 32'h80, 1'b1, 1'b0, 32'h144);
        tick();
        drive_idle();
        if_pc = 32'h100;
        #1;
        n_cmp++;
        if (pred_taken !== 1'b0 || pred_target !== 32'h104) begin
            n_fail++;
            $display("FAIL alias_old: got %b/%h want 0/00000104", pred_taken, pred_target);
        end
        if_pc = 32'h140;
        #1;
        n_cmp++;
        if (pred_taken !== 1'b1 || pred_target !== 32'h80) begin
            n_fail++;
            $display("FAIL alias_new: got %b/%h want 1/00000080", pred_taken, pred_target);
        end
    endtask

    task automatic test_invalidate();
        int exp_upd;
        exp_upd = m_upd + 1;
        drive_upd(32'h100, 1'b1, 32'h900, 1'b0, 1'b0, 32'h104);
        invalidate = 1'b1;
        tick();
        drive_idle();
        #1;
        n_cmp++;
        if (upd_count !== SB'(exp_upd)) begin
            n_fail++; $display("FAIL inval_upd_count: got %0d want %0d", upd_count, exp_upd);
        end
        for (int i = 0; i < ENT; i++) begin
            if_pc = 32'h140 + 32'(i * 4);
            #1;
            n_cmp++;
            if (pred_taken !== 1'b0) begin
                n_fail++; $display("FAIL inval_miss_%0d: got %b want 0", i, pred_taken);
            end
        end
        if_pc = 32'h100;
        #1;
        n_cmp++;
        if (pred_taken !== 1'b0) begin
            n_fail++; $display("FAIL inval_discard: got %b want 0", pred_taken);
        end
        drive_upd(32'h100, 1'b1, 32'h200, 1'b1, 1'b0, 32'h104);
        reset = 1'b1;
        tick();
        drive_idle();
        #1;
        n_cmp++;
        if (upd_count !== 0 || miss_count !== 0 || pred_taken !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_over_update: got upd=%0d miss=%0d taken=%b want 0/0/0",
                     upd_count, miss_count, pred_taken);
        end
    endtask

    task automatic test_wrong_target();
        drive_upd(32'h300, 1'b1, 32'h500, 1'b1, 1'b1, 32'h400);
        #1;
        n_cmp++;
        if (mispredict !== 1'b1) begin
            n_fail++; $display("FAIL wrong_target_flag: got %b want 1", mispredict);
        end
        tick();
        drive_idle();
        if_pc = 32'h300;
        #1;
        n_cmp++;
        if (pred_taken !== 1'b1 || pred_target !== 32'h500) begin
            n_fail++;
            $display("FAIL wrong_target_lookup: got %b/%h want 1/00000500", pred_taken,
                     pred_target);
        end
        for (int k = 0; k < (1 << SB) + 3; k++) begin
            drive_upd(32'h600, 1'b1, 32'h700, 1'b0, 1'b0, 32'h604);
            tick();
        end
        drive_idle();
        #1;
        n_cmp++;
        if (miss_count !== 8'hFF || upd_count !== 8'hFF) begin
            n_fail++;
            $display("FAIL stat_saturate: got miss=%0d upd=%0d want 255/255", miss_count,
                     upd_count);
        end
        n_cmp++;
        if (m_miss != int'(miss_count)) begin
            n_fail++; $display("FAIL stat_model: got %0d want %0d", miss_count, m_miss);
        end
    endtask

    function automatic logic [31:0] rand_pc();
        logic [31:0] tags [4];
        tags[0] = 32'h0;
        tags[1] = 32'h1;
        tags[2] = 32'h2;
        tags[3] = 32'h03FF_FFFF;
        return tags[$urandom_range(0, 3)] * (4 * ENT) + 32'($urandom_range(0, ENT - 1)) * 4
               + 32'($urandom_range(0, 3));
    endfunction

    task automatic test_random();
        logic        exp_tk, ptk;
        logic [31:0] exp_tg, ptg;
        drive_idle();
        reset = 1'b1;
        tick();
        drive_idle();
        for (int n = 0; n < 400; n++) begin
            drive_idle();
            upd_valid   = ($urandom_range(0, 3) != 0);
            upd_pc      = rand_pc();
            upd_is_jump = ($urandom_range(0, 3) == 0);
            upd_taken   = upd_is_jump ? 1'b1 : 1'($urandom_range(0, 1));
            upd_target  = ($urandom_range(0, 1) != 0) ? $urandom : upd_pc + 32'h40;
            model_lookup(upd_pc, ptk, ptg);
            upd_pred_taken  = ($urandom_range(0, 4) == 0) ? ~ptk : ptk;
            upd_pred_target = ($urandom_range(0, 4) == 0) ? $urandom : ptg;
            if (!upd_pred_taken) upd_pred_target = upd_pc + 32'd4;
            invalidate = ($urandom_range(0, 40) == 0);
            if_pc      = ($urandom_range(0, 3) == 0) ? upd_pc : rand_pc();
            #1;
            model_lookup(if_pc, exp_tk, exp_tg);
            n_cmp++;
            if (pred_taken !== exp_tk || pred_target !== exp_tg) begin
                n_fail++;
                $display("FAIL rand_lookup[%0d] pc=%h: got %b/%h want %b/%h", n, if_pc,
                         pred_taken, pred_target, exp_tk, exp_tg);
            end
            n_cmp++;
            if (mispredict !== model_mispredict()) begin
                n_fail++;
                $display("FAIL rand_mispredict[%0d]: got %b want %b", n, mispredict,
                         model_mispredict());
            end
            n_cmp++;
            if (int'(upd_count) != m_upd || int'(miss_count) != m_miss) begin
                n_fail++;
                $display("FAIL rand_counts[%0d]: got %0d/%0d want %0d/%0d", n, upd_count,
                         miss_count, m_upd, m_miss);
            end
            tick();
        end
        drive_idle();
    endtask

    initial begin
        drive_idle();
        if_pc = 32'h0;
        test_reset();
        test_taken_alloc();
        test_counter_training();
        test_alias();
        test_invalidate();
        test_wrong_target();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
